io_write_router: RTL and testbench
==================================

# io_write_router

Routes single-beat CPU store requests from the multi-cycle core to one of four memory-mapped write targets: data RAM, seven-segment display, GPIO/LED, counter. It is the distribution end of the core's data-bus path, the counterpart to the read-side selection muxes. Each store is accepted once, decoded, held stable until the target acknowledges or times out, and flagged if unmapped. It sits between the core's memory stage and the peripheral write ports.

## Interface
- N_TGT, 4, number of write targets; fixed by the decode map.
- TIMEOUT, 15, maximum SEND cycles waiting for tgt_ready before the store is dropped; legal range 2–255.
- clk  in  1  single system clock; all logic rising-edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  core presents a store.
- req_addr  in  32  byte address of the store.
- req_data  in  32  store data.
- req_ready  out  1  router accepts a store this cycle.
- tgt_valid  out  N_TGT  one-hot; bit i asserts the store toward target i.
- tgt_addr  out  32  captured address, held with tgt_valid.
- tgt_data  out  32  captured data, held with tgt_valid.
- tgt_ready  in  N_TGT  target i accepts when tgt_valid[i] and tgt_ready[i] are both 1.
- done  out  1  one-cycle pulse on successful target handshake.
- err  out  1  sticky error: unmapped address or timeout.
- err_addr  out  32  address of the most recent error.
- err_clr  in  1  clears err; err_addr is retained.

## Operation
- Decode, on req_addr, during acceptance:
  - addr[31:28]=0x0 selects target 0, RAM.
  - addr[31:28]=0xE selects target 1, seven-seg.
  - addr[31:28]=0xF with addr[2]=0 selects target 2, GPIO.
  - addr[31:28]=0xF with addr[2]=1 selects target 3, counter.
  - Anything else is unmapped.
- FSM has two states, IDLE and SEND.
- IDLE:
  - req_ready=1.
  - On req_valid: capture addr, data and the one-hot select.
  - Mapped address: go to SEND and clear the timeout counter.
  - Unmapped address: stay in IDLE; set err and load err_addr. No tgt_valid is asserted.
- SEND:
  - req_ready=0.
  - tgt_valid = captured select; tgt_addr and tgt_data stay constant.
  - tgt_ready[sel]=1: go to IDLE and pulse done.
  - Otherwise increment the timeout counter.
  - If the counter reaches TIMEOUT-1 without a handshake: go to IDLE, set err, load err_addr, no done.
  - tgt_ready bits of non-selected targets are ignored.
- Timeout counter is 8 bits and saturates; it is never observed outside SEND.
- If err_clr and a new error occur in the same cycle, the set wins. err_addr takes the new address.

## Timing
- Reset values: state=IDLE, req_ready=1 in the cycle after reset, tgt_valid=0, tgt_addr=0, tgt_data=0, done=0, err=0, err_addr=0, counter=0.
- Accept edge is cycle 0. tgt_valid is high from cycle 1.
- If tgt_ready is high in cycle 1, the handshake occurs at the end of cycle 1. done is high in cycle 2 and req_ready is high in cycle 2.
- Best-case throughput is one store per 2 cycles.
- Unmapped store: err is high in cycle 1 and req_ready stays 1, so back-to-back acceptance is allowed.
- Timeout: the store occupies SEND for exactly TIMEOUT cycles. err rises in the cycle after the last SEND cycle.
- rst in any state, including mid-SEND, returns the block to reset values at the next edge. The pending store is lost and no done is issued.
- tgt_valid never deasserts in SEND before the handshake or the timeout.

## Structure
- Package io_map_pkg holds:
  - target index constants TGT_RAM=0, TGT_SEG=1, TGT_GPIO=2, TGT_CNT=3;
  - decode nibbles 4'h0, 4'hE, 4'hF;
  - state encoding IDLE and SEND;
  - the N_TGT constant.
- Sub-module addr_decode is combinational: req_addr in, one-hot select and a mapped flag out. It is reused by the read-side path.
- Top level contains the FSM, capture registers, timeout counter and error registers.

## Test plan
- RAM store, ready already high: addr 0x0000_0040, data 0xDEADBEEF, tgt_ready=4'b0001. Required: tgt_valid=4'b0001 in cycle 1 with addr and data stable; done in cycle 2; req_ready=1 in cycle 2.
- Stalled GPIO target: addr 0xF000_0000, tgt_ready[2] low for 5 cycles, then high. Required: tgt_valid=4'b0100 held 6 cycles, data unchanged, one done, err=0.
- Unmapped addresses back-to-back: 0x8000_0000 then 0x0000_0004. Required: err=1, err_addr=0x8000_0000, no tgt_valid for the first store; the second store goes to target 0 normally.
- Timeout: addr 0xF000_0004 with tgt_ready=0 forever. Required: tgt_valid=4'b1000 for 15 cycles, then deasserts; err=1, err_addr=0xF000_0004, no done.
- Wrong-target ready: addr 0xE000_0000 with tgt_ready=4'b0001. Required: tgt_valid=4'b0010 remains asserted and the handshake is not taken.
- Reset mid-SEND: rst pulsed in cycle 3 of a stalled store. Required: next cycle tgt_valid=0, req_ready=1, err=0, done never pulses.
- Clear/set collision: err_clr asserted in the same cycle a new unmapped store 0x9000_0000 is accepted. Required: err stays 1, err_addr=0x9000_0000.

Source files
------------

// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - shared write-side memory map constants and router state encoding
package io_map_pkg;

    // Number of write targets; fixed by the decode map below.
    localparam int N_TGT = 4;

    // Bit positions of each target in the one-hot select.
    localparam int TGT_RAM  = 0;
    localparam int TGT_SEG  = 1;
    localparam int TGT_GPIO = 2;
    localparam int TGT_CNT  = 3;

    // Decode nibbles matched against addr[31:28].
    localparam logic [3:0] NIB_RAM = 4'h0;
    localparam logic [3:0] NIB_SEG = 4'hE;
    localparam logic [3:0] NIB_IO  = 4'hF;  // GPIO or counter, split on addr[2]

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/addr_decode.sv
// rtl/addr_decode.sv - combinational store-address decoder shared by read and write paths
// Ports:
//   req_addr  in  32     byte address to decode
//   sel       out N_TGT  one-hot target select, all zero when unmapped
//   mapped    out 1      address hits one of the targets
module addr_decode
    import io_map_pkg::*;
(
    input  logic [31:0]      req_addr,
    output logic [N_TGT-1:0] sel,
    output logic             mapped
);

    always_comb begin
        sel = '0;
        case (req_addr[31:28])
            NIB_RAM: sel[TGT_RAM] = 1'b1;
            NIB_SEG: sel[TGT_SEG] = 1'b1;
            NIB_IO: begin
                // The I/O page holds two word-sized registers; addr[2] picks between them.
                if (req_addr[2]) begin
                    sel[TGT_CNT] = 1'b1;
                end else begin
                    sel[TGT_GPIO] = 1'b1;
                end
            end
            default: sel = '0;
        endcase
    end

    assign mapped = |sel;

    // Only the page nibble and the register-select bit take part in decoding.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[27:3], req_addr[1:0]};

endmodule

// File: rtl/io_write_router.sv
// rtl/io_write_router.sv - routes single-beat core stores to RAM, seven-seg, GPIO or counter
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/ready      store request handshake from the core
//   req_addr, req_data   store address and data
//   tgt_valid            one-hot store strobe toward the selected target
//   tgt_addr, tgt_data   captured store, held while tgt_valid is up
//   tgt_ready            per-target accept
//   done                 one-cycle pulse after a target handshake
//   err, err_addr        sticky unmapped/timeout flag and the offending address
//   err_clr              clears err (a simultaneous new error wins)
module io_write_router
    import io_map_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_data,
    output logic             req_ready,
    output logic [N_TGT-1:0] tgt_valid,
    output logic [31:0]      tgt_addr,
    output logic [31:0]      tgt_data,
    input  logic [N_TGT-1:0] tgt_ready,
    output logic             done,
    output logic             err,
    output logic [31:0]      err_addr,
    input  logic             err_clr
);

    // Count value seen in the final SEND cycle; SEND lasts exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [N_TGT-1:0] sel_q, sel_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      err_addr_q, err_addr_d;

    logic [N_TGT-1:0] dec_sel;
    logic             dec_mapped;
    logic             err_set;
    logic [31:0]      err_set_addr;

    addr_decode u_addr_decode (
        .req_addr (req_addr),
        .sel      (dec_sel),
        .mapped   (dec_mapped)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        err_d        = err_q;
        err_addr_d   = err_addr_q;
        err_set      = 1'b0;
        err_set_addr = req_addr;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    sel_d  = dec_sel;
                    if (dec_mapped) begin
                        state_d = SEND;
                        cnt_d   = 8'd0;
                    end else begin
                        // Unmapped stores are dropped in place so the core is never stalled.
                        err_set      = 1'b1;
                        err_set_addr = req_addr;
                    end
                end
            end
            SEND: begin
                // A handshake in the final cycle still completes the store.
                if (|(tgt_ready & sel_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = IDLE;
                    err_set      = 1'b1;
                    err_set_addr = addr_q;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Setting beats clearing so an error arriving with err_clr is never lost.
        if (err_set) begin
            err_d      = 1'b1;
            err_addr_d = err_set_addr;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign tgt_valid = (state_q == SEND) ? sel_q : '0;
    assign tgt_addr  = addr_q;
    assign tgt_data  = data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_io_write_router.sv
// tb/tb_io_write_router.sv - randomized self-checking bench for io_write_router
module tb_io_write_router;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_ready;
    logic [3:0]  tgt_valid;
    logic [31:0] tgt_addr;
    logic [31:0] tgt_data;
    logic [3:0]  tgt_ready;
    logic        done;
    logic        err;
    logic [31:0] err_addr;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    // Reference state: sticky error flag and address as seen from outside.
    logic        err_m;
    logic [31:0] err_addr_m;

    always #5 clk = ~clk;

    io_write_router #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tgt_valid (tgt_valid),
        .tgt_addr  (tgt_addr),
        .tgt_data  (tgt_data),
        .tgt_ready (tgt_ready),
        .done      (done),
        .err       (err),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Memory map as a lookup: page nibble -> target, I/O page split by word.
    function automatic logic [3:0] target_of(input logic [31:0] a);
        int page;
        page = int'(a >> 28);
        if (page == 0)  return 4'b0001;
        if (page == 14) return 4'b0010;
        if (page == 15) return ((a / 4) % 2 == 1) ? 4'b1000 : 4'b0100;
        return 4'b0000;
    endfunction

    // Issue one store at a negedge with the target withholding ready for
    // 'stall' SEND cycles. Returns at the negedge of the first free cycle.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input int stall,
                         input logic clr, input logic use_fix, input logic [3:0] other_fix);
        logic [3:0] oh;
        logic [3:0] others;
        bit         ok;
        int         n;
        oh = target_of(a);
        chk("req_ready_before", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        err_clr   = clr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        err_clr   = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        if (oh == 4'b0000) begin
            err_m      = 1'b1;
            err_addr_m = a;
            chk("unmapped_tgt_valid", {28'b0, tgt_valid}, 32'd0);
            chk("unmapped_err", {31'b0, err}, 32'd1);
            chk("unmapped_err_addr", err_addr, a);
            chk("unmapped_req_ready", {31'b0, req_ready}, 32'd1);
            chk("unmapped_done", {31'b0, done}, 32'd0);
            return;
        end
        if (clr) err_m = 1'b0;
        ok = (stall < TO);
        n  = ok ? stall + 1 : TO;
        for (int k = 1; k <= n; k++) begin
            others    = use_fix ? other_fix : 4'($urandom);
            tgt_ready = (others & ~oh) | ((k > stall) ? oh : 4'b0000);
            chk("send_tgt_valid", {28'b0, tgt_valid}, {28'b0, oh});
            chk("send_tgt_addr", tgt_addr, a);
            chk("send_tgt_data", tgt_data, d);
            chk("send_req_ready", {31'b0, req_ready}, 32'd0);
            chk("send_done", {31'b0, done}, 32'd0);
            chk("send_err", {31'b0, err}, {31'b0, err_m});
            @(negedge clk);
        end
        tgt_ready = 4'b0000;
        if (!ok) begin
            err_m      = 1'b1;
            err_addr_m = a;
        end
        chk("end_done", {31'b0, done}, {31'b0, ok});
        chk("end_req_ready", {31'b0, req_ready}, 32'd1);
        chk("end_tgt_valid", {28'b0, tgt_valid}, 32'd0);
        chk("end_err", {31'b0, err}, {31'b0, err_m});
        chk("end_err_addr", err_addr, err_addr_m);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  pages [5];
        int          stall;

        pages[0] = 4'h0;
        pages[1] = 4'hE;
        pages[2] = 4'hF;
        pages[3] = 4'hF;
        pages[4] = 4'h5;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        tgt_ready = '0;
        err_clr   = 1'b0;
        err_m     = 1'b0;
        err_addr_m = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_tgt_valid", {28'b0, tgt_valid}, 32'd0);
        chk("rst_tgt_addr", tgt_addr, 32'd0);
        chk("rst_tgt_data", tgt_data, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);

        // Directed cases
        store(32'h0000_0040, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 4'b0001);
        store(32'hF000_0000, 32'h1234_5678, 5, 1'b0, 1'b0, 4'b0000);
        store(32'h8000_0000, 32'h0BAD_0BAD, 0, 1'b0, 1'b0, 4'b0000);
        store(32'h0000_0004, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 4'b0000);
        store(32'hF000_0004, 32'h5555_AAAA, 1000, 1'b0, 1'b1, 4'b0000);
        store(32'hE000_0000, 32'h0000_00E5, 4, 1'b0, 1'b1, 4'b0001);
        store(32'hE000_0000, 32'h0000_0014, 14, 1'b0, 1'b0, 4'b0000);
        store(32'h9000_0000, 32'h0000_0099, 0, 1'b1, 1'b0, 4'b0000);

        // Reset during a stalled store
        req_valid = 1'b1;
        req_addr  = 32'hF000_0000;
        req_data  = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk("rstsend_tgt_valid", {28'b0, tgt_valid}, 32'h4);
            if (k == 3) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        err_m = 1'b0;
        err_addr_m = '0;
        chk("rstsend_tgt_valid_after", {28'b0, tgt_valid}, 32'd0);
        chk("rstsend_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rstsend_err", {31'b0, err}, 32'd0);
        chk("rstsend_err_addr", err_addr, 32'd0);
        tgt_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            chk("rstsend_done", {31'b0, done}, 32'd0);
            @(negedge clk);
        end
        tgt_ready = 4'h0;

        // Randomized stores
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            a[31:28] = pages[$urandom_range(0, 4)];
            if (a[31:28] == 4'h5) a[31:28] = 4'($urandom_range(1, 13));
            case ($urandom_range(0, 5))
                0, 1, 2: stall = $urandom_range(0, 3);
                3:       stall = $urandom_range(13, 16);
                4:       stall = 100;
                default: stall = $urandom_range(4, 10);
            endcase
            store(a, $urandom, stall, ($urandom_range(0, 3) == 0), 1'b0, 4'b0000);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
